multihand_scorer: RTL and testbench

Sequential, parametrised baccarat scoring engine for the task4 datapath. Cards arrive one per cycle over a valid/ready handshake, each tagged with a hand index. The block keeps a running modulo score and card count per hand. On request it scans all hands over several cycles and reports the winning hand or a tie. It replaces per-hand combinational scoring, and the controller FSM reads the result directly.

---
 rtl/multihand_scorer_if.sv | 25 ++
 rtl/multihand_scorer.sv | 130 +++++++++++++
 tb/tb_multihand_scorer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/multihand_scorer_if.sv
// multihand_scorer_if: card handshake, control and result bundle for multihand_scorer
interface multihand_scorer_if #(parameter int NUM_HANDS = 2);
  localparam int HW = $clog2(NUM_HANDS);
  logic                   clear;
  logic                   card_valid;
  logic                   card_ready;
  logic [HW-1:0]          card_hand;
  logic [3:0]             card;
  logic                   eval;
  logic [4*NUM_HANDS-1:0] scores;
  logic [3*NUM_HANDS-1:0] counts;
  logic [HW-1:0]          winner;
  logic                   tie;
  logic                   result_valid;
  logic                   err;
  logic [NUM_HANDS-1:0]   natural;
  modport master (
    output clear, card_valid, card_hand, card, eval,
    input  card_ready, scores, counts, winner, tie, result_valid, err, natural
  );
  modport slave (
    input  clear, card_valid, card_hand, card, eval,
    output card_ready, scores, counts, winner, tie, result_valid, err, natural
  );
endinterface

// File: rtl/multihand_scorer.sv
// multihand_scorer: per-hand modulo baccarat scoring with multi-cycle winner scan; SCOREHAND_NATURAL_EN enables natural detection/stand
module multihand_scorer #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  parameter int MODULUS   = 10
) (
  input logic              slow_clock,
  input logic              resetb,
  multihand_scorer_if.slave bus
);
  localparam int HW = $clog2(NUM_HANDS);
`ifdef SCOREHAND_NATURAL_EN
  localparam bit NAT_EN = 1'b1;
`else
  localparam bit NAT_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;
  state_t               state_q, state_d;
  logic [3:0]           scores_q [NUM_HANDS];
  logic [3:0]           scores_d [NUM_HANDS];
  logic [2:0]           counts_q [NUM_HANDS];
  logic [2:0]           counts_d [NUM_HANDS];
  logic [NUM_HANDS-1:0] nat_q, nat_d;
  logic                 err_q, err_d, tie_q, tie_d, rv_q, rv_d;
  logic [HW-1:0]        best_idx_q, best_idx_d, scan_idx_q, scan_idx_d;
  logic [3:0]           best_score_q, best_score_d;
  logic                 accepting, xfer, legal;
  logic [3:0]           val;
  logic [4:0]           sum;
  assign accepting      = state_q == IDLE || state_q == ACCUM;
  assign bus.card_ready = accepting && !bus.clear;
  assign xfer           = bus.card_valid && bus.card_ready;
  assign val            = bus.card <= 4'd9 ? bus.card : 4'd0;
  always_comb begin
    state_d      = state_q;
    scores_d     = scores_q;
    counts_d     = counts_q;
    nat_d        = nat_q;
    err_d        = err_q;
    tie_d        = tie_q;
    rv_d         = rv_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    scan_idx_d   = scan_idx_q;
    legal        = 1'b0;
    sum          = '0;
    if (xfer) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        if (bus.card_hand == HW'(h) && bus.card >= 4'd1 && bus.card <= 4'd13 &&
            counts_q[h] < 3'(MAX_CARDS) && !(NAT_EN && nat_q[h])) begin
          legal       = 1'b1;
          sum         = {1'b0, scores_q[h]} + {1'b0, val};
          scores_d[h] = 4'(sum % 5'(MODULUS));
          counts_d[h] = counts_q[h] + 3'd1;
          nat_d[h]    = NAT_EN && counts_d[h] == 3'd2 && scores_d[h] >= 4'(MODULUS - 2);
        end
      end
      err_d = err_q || !legal;
      if (legal && state_q == IDLE) state_d = ACCUM;
    end
    // The scan seeds from the post-edge scores so a card arriving with eval is counted.
    if (accepting && bus.eval) begin
      best_idx_d   = '0;
      best_score_d = scores_d[0];
      tie_d        = 1'b0;
      scan_idx_d   = HW'(1);
      state_d      = SCAN;
    end
    if (state_q == SCAN) begin
      if (scores_q[scan_idx_q] > best_score_q) begin
        best_idx_d   = scan_idx_q;
        best_score_d = scores_q[scan_idx_q];
        tie_d        = 1'b0;
      end else if (scores_q[scan_idx_q] == best_score_q) begin
        tie_d = 1'b1;
      end
      scan_idx_d = scan_idx_q + HW'(1);
      if (scan_idx_q == HW'(NUM_HANDS - 1)) begin
        state_d = DONE;
        rv_d    = 1'b1;
      end
    end
    if (bus.clear) begin
      state_d      = IDLE;
      scores_d     = '{default: '0};
      counts_d     = '{default: '0};
      nat_d        = '0;
      err_d        = 1'b0;
      tie_d        = 1'b0;
      rv_d         = 1'b0;
      best_idx_d   = '0;
      best_score_d = '0;
      scan_idx_d   = '0;
    end
  end
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      scores_q     <= '{default: '0};
      counts_q     <= '{default: '0};
      nat_q        <= '0;
      err_q        <= 1'b0;
      tie_q        <= 1'b0;
      rv_q         <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      scan_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      scores_q     <= scores_d;
      counts_q     <= counts_d;
      nat_q        <= nat_d;
      err_q        <= err_d;
      tie_q        <= tie_d;
      rv_q         <= rv_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      scan_idx_q   <= scan_idx_d;
    end
  end
  for (genvar g = 0; g < NUM_HANDS; g++) begin : g_out
    assign bus.scores[4*g +: 4] = scores_q[g];
    assign bus.counts[3*g +: 3] = counts_q[g];
  end
  assign bus.natural      = nat_q;
  assign bus.err          = err_q;
  assign bus.tie          = tie_q;
  assign bus.winner       = best_idx_q;
  assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_multihand_scorer.sv
// tb_multihand_scorer: vector table on a 2-hand scorer plus model-checked random and corner sequences on a 3-hand scorer
module tb_multihand_scorer;
  localparam int MC = 3;
  localparam int MD = 10;
`ifdef SCOREHAND_NATURAL_EN
  localparam bit NAT = 1'b1;
`else
  localparam bit NAT = 1'b0;
`endif
  logic clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0;
  always #5 clk = ~clk;
  multihand_scorer_if #(.NUM_HANDS(2)) ia ();
  multihand_scorer_if #(.NUM_HANDS(3)) ib ();
  multihand_scorer #(.NUM_HANDS(2), .MAX_CARDS(MC), .MODULUS(MD)) dut_a (.slow_clock(clk), .resetb(rst_a), .bus(ia));
  multihand_scorer #(.NUM_HANDS(3), .MAX_CARDS(MC), .MODULUS(MD)) dut_b (.slow_clock(clk), .resetb(rst_b), .bus(ib));
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  typedef struct {
    bit clr, v; int h, c; bit ev; bit rdy;
    int s0, s1, c0, c1; bit er, rv; int w, t, nat;
  } row_t;
  row_t tbl[$];
  function automatic row_t r(bit clr, bit v, int h, int c, bit ev, bit rdy,
                             int s0, int s1, int c0, int c1, bit er, bit rv, int w, int t, int nat);
    row_t x;
    x.clr = clr; x.v = v; x.h = h; x.c = c; x.ev = ev; x.rdy = rdy;
    x.s0 = s0; x.s1 = s1; x.c0 = c0; x.c1 = c1; x.er = er; x.rv = rv; x.w = w; x.t = t; x.nat = nat;
    return x;
  endfunction
  function automatic row_t rc();
    return r(1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  task automatic run_row(input row_t x, input int i);
    ia.clear = x.clr; ia.card_valid = x.v; ia.card_hand = 1'(x.h); ia.card = 4'(x.c); ia.eval = x.ev;
    #1;
    chk($sformatf("a_ready[%0d]", i), int'(ia.card_ready), int'(x.rdy));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("a_score0[%0d]", i), int'(ia.scores[3:0]), x.s0);
    chk($sformatf("a_score1[%0d]", i), int'(ia.scores[7:4]), x.s1);
    chk($sformatf("a_count0[%0d]", i), int'(ia.counts[2:0]), x.c0);
    chk($sformatf("a_count1[%0d]", i), int'(ia.counts[5:3]), x.c1);
    chk($sformatf("a_err[%0d]", i), int'(ia.err), int'(x.er));
    chk($sformatf("a_rv[%0d]", i), int'(ia.result_valid), int'(x.rv));
    chk($sformatf("a_natural[%0d]", i), int'(ia.natural), x.nat);
    if (x.rv) begin
      chk($sformatf("a_winner[%0d]", i), int'(ia.winner), x.w);
      chk($sformatf("a_tie[%0d]", i), int'(ia.tie), x.t);
    end
  endtask
  // Reference for the 3-hand scorer: hand totals, a flag for "still taking cards",
  // and a countdown to the moment the result becomes visible.
  int msc[3], mcnt[3], mrem, mwin, mtie;
  bit merr, macc, mdone;
  function automatic bit mnat(int h);
    return NAT && mcnt[h] == 2 && msc[h] >= MD - 2;
  endfunction
  task automatic model_clear();
    for (int h = 0; h < 3; h++) begin msc[h] = 0; mcnt[h] = 0; end
    merr = 0; macc = 1; mdone = 0; mrem = 0; mwin = 0; mtie = 0;
  endtask
  task automatic step_b(input bit clr, input bit v, input int h, input int c, input bit ev);
    int best, nb;
    ib.clear = clr; ib.card_valid = v; ib.card_hand = 2'(h); ib.card = 4'(c); ib.eval = ev;
    #1;
    chk("b_ready", int'(ib.card_ready), int'(macc && !clr));
    @(posedge clk);
    if (clr) model_clear();
    else if (macc) begin
      if (v) begin
        if (c >= 1 && c <= 13 && h < 3 && mcnt[h] < MC && !mnat(h)) begin
          msc[h] = (msc[h] + (c <= 9 ? c : 0)) % MD;
          mcnt[h]++;
        end else merr = 1;
      end
      if (ev) begin
        best = -1; nb = 0;
        for (int k = 0; k < 3; k++) if (msc[k] > best) begin best = msc[k]; mwin = k; end
        for (int k = 0; k < 3; k++) if (msc[k] == best) nb++;
        mtie = nb > 1;
        macc = 0; mrem = 2;
      end
    end else if (!mdone) begin
      mrem--;
      if (mrem == 0) mdone = 1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b_score%0d", k), int'(ib.scores[4*k +: 4]), msc[k]);
      chk($sformatf("b_count%0d", k), int'(ib.counts[3*k +: 3]), mcnt[k]);
      chk($sformatf("b_natural%0d", k), int'(ib.natural[k]), int'(mnat(k)));
    end
    chk("b_err", int'(ib.err), int'(merr));
    chk("b_rv", int'(ib.result_valid), int'(mdone));
    if (mdone) begin
      chk("b_winner", int'(ib.winner), mwin);
      chk("b_tie", int'(ib.tie), mtie);
    end
  endtask
  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) step_b(0, 0, 0, 0, 0);
  endtask
  initial begin
    ia.clear = 0; ia.card_valid = 0; ia.card_hand = '0; ia.card = '0; ia.eval = 0;
    ib.clear = 0; ib.card_valid = 0; ib.card_hand = '0; ib.card = '0; ib.eval = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_scores", int'(ia.scores), 0);
    chk("rst_a_counts", int'(ia.counts), 0);
    chk("rst_a_rv", int'(ia.result_valid), 0);
    chk("rst_a_flags", int'({ia.err, ia.tie, ia.winner, ia.natural}), 0);
    chk("rst_b_scores", int'(ib.scores), 0);
    chk("rst_b_flags", int'({ib.err, ib.tie, ib.winner, ib.natural, ib.result_valid}), 0);
    rst_a = 1; rst_b = 1;
    #1;
    chk("rst_a_ready", int'(ia.card_ready), 1);
    chk("rst_b_ready", int'(ib.card_ready), 1);
    @(negedge clk);
    tbl.push_back(r(0,1,0,7,0, 1, 7,0,1,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,0,5,0, 1, 2,0,2,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,0,13,0,1, 2,0,3,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,1,4,0, 1, 2,4,3,1, 0,0,0,0,0));
    tbl.push_back(r(0,1,1,3,0, 1, 2,7,3,2, 0,0,0,0,0));
    tbl.push_back(r(0,0,0,0,1, 1, 2,7,3,2, 0,0,0,0,0));
    tbl.push_back(r(0,1,0,9,0, 0, 2,7,3,2, 0,1,1,0,0));
    tbl.push_back(r(0,1,1,2,1, 0, 2,7,3,2, 0,1,1,0,0));
    tbl.push_back(rc());
    tbl.push_back(r(0,1,0,0,0, 1, 0,0,0,0, 1,0,0,0,0));
    tbl.push_back(r(0,1,1,15,0,1, 0,0,0,0, 1,0,0,0,0));
    tbl.push_back(rc());
    tbl.push_back(r(0,1,1,14,0,1, 0,0,0,0, 1,0,0,0,0));
    tbl.push_back(rc());
    tbl.push_back(r(0,1,0,10,0,1, 0,0,1,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,0,12,0,1, 0,0,2,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,0,1,0, 1, 1,0,3,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,0,4,0, 1, 1,0,3,0, 1,0,0,0,0));
    tbl.push_back(rc());
    tbl.push_back(r(0,1,0,5,0, 1, 5,0,1,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,1,9,1, 1, 5,9,1,1, 0,0,0,0,0));
    tbl.push_back(r(0,0,0,0,0, 0, 5,9,1,1, 0,1,1,0,0));
    tbl.push_back(rc());
    tbl.push_back(r(0,1,0,6,0, 1, 6,0,1,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,1,6,0, 1, 6,6,1,1, 0,0,0,0,0));
    tbl.push_back(r(0,0,0,0,1, 1, 6,6,1,1, 0,0,0,0,0));
    tbl.push_back(r(0,0,0,0,0, 0, 6,6,1,1, 0,1,0,1,0));
    tbl.push_back(rc());
    tbl.push_back(r(0,0,0,0,1, 1, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(r(0,0,0,0,0, 0, 0,0,0,0, 0,1,0,1,0));
    tbl.push_back(rc());
    tbl.push_back(r(0,1,1,9,0, 1, 0,9,0,1, 0,0,0,0,0));
    tbl.push_back(r(0,1,1,8,0, 1, 0,7,0,2, 0,0,0,0,0));
    tbl.push_back(r(0,1,1,7,0, 1, 0,4,0,3, 0,0,0,0,0));
    tbl.push_back(rc());
    tbl.push_back(r(0,1,0,4,0, 1, 4,0,1,0, 0,0,0,0,0));
    tbl.push_back(r(0,1,0,5,0, 1, 9,0,2,0, 0,0,0,0, NAT ? 1 : 0));
    tbl.push_back(r(0,1,0,3,0, 1, NAT ? 9 : 2, 0, NAT ? 2 : 3, 0, NAT, 0,0,0, NAT ? 1 : 0));
    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);
    model_clear();
    step_b(0,1,0,6,0); step_b(0,1,1,6,0); step_b(0,1,2,3,0); step_b(0,0,0,0,1);
    step_b(0,0,0,0,0);
    chk("b_tie_rv_early", int'(ib.result_valid), 0);
    step_b(0,0,0,0,0);
    chk("b_tie_rv", int'(ib.result_valid), 1);
    chk("b_tie_winner", int'(ib.winner), 0);
    chk("b_tie_flag", int'(ib.tie), 1);
    step_b(1,0,0,0,0);
    step_b(0,1,0,4,0); step_b(0,1,1,9,0); step_b(0,1,2,9,0); step_b(0,0,0,0,1);
    idle_b(2);
    chk("b_tie2_winner", int'(ib.winner), 1);
    chk("b_tie2_flag", int'(ib.tie), 1);
    step_b(0,1,3,5,0);
    step_b(1,0,0,0,0);
    step_b(0,1,3,5,0);
    chk("b_bad_hand_err", int'(ib.err), 1);
    step_b(1,0,0,0,0);
    step_b(0,1,0,5,0); step_b(0,1,1,7,0); step_b(0,0,0,0,1); step_b(0,0,0,0,0);
    rst_b = 0;
    #1;
    chk("b_midscan_scores", int'(ib.scores), 0);
    chk("b_midscan_counts", int'(ib.counts), 0);
    chk("b_midscan_flags", int'({ib.err, ib.tie, ib.winner, ib.result_valid}), 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_b = 1;
    for (int i = 0; i < 4; i++) begin
      step_b(0,0,0,0,0);
      chk("b_midscan_no_rv", int'(ib.result_valid), 0);
    end
    for (int i = 0; i < 600; i++) begin
      bit clr, v, ev;
      int h, c;
      clr = $urandom_range(0, 29) == 0;
      v   = $urandom_range(0, 1) == 1;
      ev  = $urandom_range(0, 11) == 0;
      h   = $urandom_range(0, 3);
      c   = $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(1, 13);
      step_b(clr, v, h, c, ev);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
